// File: rtl/muldiv_pkg.sv
// Shared encodings and latched-operation control for the EX-stage multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned MD_ITER = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    // Operation attributes captured at start and consumed in FIX
    typedef struct packed {
        logic is_div;
        logic qsign;
        logic rsign;
        logic dz;
    } md_ctl_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-to-muldiv request bus and HI/LO/status return path.
interface ex_muldiv_unit_if #(parameter int unsigned WIDTH = 32);

    logic             EX_start;
    logic [1:0]       EX_MDOp;
    logic [WIDTH-1:0] EX_dataA;
    logic [WIDTH-1:0] EX_dataB;
    logic             EX_HIWr;
    logic             EX_LOWr;
    logic [WIDTH-1:0] EX_wdata;
    logic             EX_abort;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             MD_busy;
    logic             MD_done;

    modport master (
        output EX_start, EX_MDOp, EX_dataA, EX_dataB, EX_HIWr, EX_LOWr, EX_wdata, EX_abort,
        input  HI, LO, MD_busy, MD_done
    );

    modport slave (
        input  EX_start, EX_MDOp, EX_dataA, EX_dataB, EX_HIWr, EX_LOWr, EX_wdata, EX_abort,
        output HI, LO, MD_busy, MD_done
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide trial subtract.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    input  logic             is_div,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] trial;

    always_comb begin
        add_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
        trial   = {hi_in, lo_in[WIDTH-1]} - {1'b0, operand};
        hi_out  = '0;
        lo_out  = '0;
        if (is_div) begin
            // No borrow means the shifted remainder covers the divisor
            if (!trial[WIDTH]) begin
                hi_out = trial[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = {hi_in[WIDTH-2:0], lo_in[WIDTH-1]};
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            {hi_out, lo_out} = {add_sum, lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit with HI/LO and mthi/mtlo.
// MULDIV_FAST_MUL_EN selects a single-cycle multiply; divide stays iterative.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    ex_muldiv_unit_if.slave  md
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, operand;
    md_ctl_t          ctl;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             busy_r, done_r;

    logic             start_go, wr_go, calc_go, fix_go, calc_last;
    logic             in_div, a_neg, b_neg, dz_in;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [PW-1:0]    prod, prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .hi_in   (acc_hi),
        .lo_in   (acc_lo),
        .operand (operand),
        .is_div  (ctl.is_div),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // Operand conditioning and final sign correction
    always_comb begin
        in_div = op_is_div(md.EX_MDOp);
        a_neg  = op_is_signed(md.EX_MDOp) & md.EX_dataA[WIDTH-1];
        b_neg  = op_is_signed(md.EX_MDOp) & md.EX_dataB[WIDTH-1];
        abs_a  = a_neg ? -md.EX_dataA : md.EX_dataA;
        abs_b  = b_neg ? -md.EX_dataB : md.EX_dataB;
        dz_in  = in_div & (md.EX_dataB == '0);

        prod     = {acc_hi, acc_lo};
        prod_fix = ctl.qsign ? -prod : prod;
        fix_hi   = prod_fix[PW-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (ctl.dz) begin
            fix_hi = acc_hi;
            fix_lo = acc_lo;
        end else if (ctl.is_div) begin
            fix_hi = ctl.rsign ? -acc_hi : acc_hi;
            fix_lo = ctl.qsign ? -acc_lo : acc_lo;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        wr_go     = 1'b0;
        calc_go   = 1'b0;
        fix_go    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
        calc_last = !ctl.is_div || (cnt == CNT_W'(WIDTH - 1));
`else
        calc_last = (cnt == CNT_W'(WIDTH - 1));
`endif
        case (state)
            MD_IDLE: begin
                if (!md.EX_abort) begin
                    if (md.EX_start) begin
                        start_go  = 1'b1;
                        state_nxt = dz_in ? MD_FIX : MD_CALC;
                    end else begin
                        wr_go = md.EX_HIWr | md.EX_LOWr;
                    end
                end
            end
            MD_CALC: begin
                if (md.EX_abort) begin
                    state_nxt = MD_IDLE;
                end else begin
                    calc_go = 1'b1;
                    if (calc_last) state_nxt = MD_FIX;
                end
            end
            MD_FIX: begin
                state_nxt = MD_IDLE;
                fix_go    = !md.EX_abort;
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    // Datapath, counter and architectural HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            ctl     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_nxt != MD_IDLE);
            done_r <= fix_go;
            if (start_go) begin
                cnt        <= '0;
                ctl.is_div <= in_div;
                ctl.qsign  <= a_neg ^ b_neg;
                ctl.rsign  <= a_neg;
                ctl.dz     <= dz_in;
                operand    <= in_div ? abs_b : abs_a;
                // Divide by zero preloads the architectural result directly
                acc_hi     <= dz_in ? md.EX_dataA : '0;
                acc_lo     <= dz_in ? '1 : (in_div ? abs_a : abs_b);
            end
            if (wr_go) begin
                if (md.EX_HIWr) hi_r <= md.EX_wdata;
                if (md.EX_LOWr) lo_r <= md.EX_wdata;
            end
            if (calc_go) begin
                cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_FAST_MUL_EN
                if (!ctl.is_div) begin
                    {acc_hi, acc_lo} <= PW'(operand) * PW'(acc_lo);
                end else begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                end
`else
                acc_hi <= step_hi;
                acc_lo <= step_lo;
`endif
            end
            if (fix_go) begin
                hi_r <= fix_hi;
                lo_r <= fix_lo;
            end
        end
    end

    assign md.HI      = hi_r;
    assign md.LO      = lo_r;
    assign md.MD_busy = busy_r;
    assign md.MD_done = done_r;

endmodule
